mips_hilo_sequencer: RTL and testbench

Multi-cycle sequencer for the MIPS CPU's multiply/divide resource. It owns the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode and runs 32-iteration shift-add multiply or restoring divide on operand magnitudes, followed by a sign fix-up. It stalls the single-cycle core whenever a new HI/LO op or an MFHI/MFLO read arrives while an operation is in flight.

---
 rtl/mips_hilo_sequencer_if.sv | 26 ++
 rtl/mips_hilo_sequencer.sv | 139 +++++++++++++
 tb/tb_mips_hilo_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_hilo_sequencer_if.sv
// Decode <-> HI/LO sequencer bus: issue strobe, operands, MFHI/MFLO read
// indication, and the sequencer's status and HI/LO register outputs.
interface mips_hilo_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hilo_read;
  logic             op_ready;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op_code, op_a, op_b, hilo_read,
    input  op_ready, busy, stall, hi, lo
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, hilo_read,
    output op_ready, busy, stall, hi, lo
  );
endinterface

// File: rtl/mips_hilo_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the MIPS HI/LO registers.
// Shift-add multiply and restoring divide run on operand magnitudes for
// WIDTH iterations, then a FIX cycle applies signs and writes HI/LO.
module mips_hilo_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clock_enable,
  mips_hilo_sequencer_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;   // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;     // negate product / quotient
  logic               neg_r;     // negate remainder
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes, iteration arithmetic and sign fix-up values
  always_comb begin
    // op_code[0] clear selects the signed variant of MULT/DIV
    sign_a   = ~bus.op_code[0] & bus.op_a[WIDTH-1];
    sign_b   = ~bus.op_code[0] & bus.op_b[WIDTH-1];
    mag_a    = sign_a ? -bus.op_a : bus.op_a;
    mag_b    = sign_b ? -bus.op_b : bus.op_b;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & operand};
    // 33-bit compare so a full-scale magnitude divides correctly
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, operand};
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer FSM, datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (clock_enable) begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            case (bus.op_code)
              3'b100: hi_q <= bus.op_a;
              3'b101: lo_q <= bus.op_a;
              3'b000, 3'b001: begin
                operand <= mag_a;
                acc     <= {{WIDTH{1'b0}}, mag_b};
                neg_q   <= sign_a ^ sign_b;
                neg_r   <= 1'b0;
                is_div  <= 1'b0;
                cnt     <= '0;
                state   <= MUL;
              end
              3'b010, 3'b011: begin
                is_div <= 1'b1;
                cnt    <= '0;
                if (bus.op_b == '0) begin
                  // Divide by zero: FIX writes HI = dividend, LO = all ones
                  acc   <= {bus.op_a, {WIDTH{1'b1}}};
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                  state <= FIX;
                end else begin
                  acc     <= {{WIDTH{1'b0}}, mag_a};
                  operand <= mag_b;
                  neg_q   <= sign_a ^ sign_b;
                  neg_r   <= sign_a;
                  state   <= DIV;
                end
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        DIV: begin
          if (!rem_diff[WIDTH])
            acc <= {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else
            acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status decode and HI/LO outputs
  always_comb begin
    bus.op_ready = (state == IDLE);
    bus.busy     = (state != IDLE);
    bus.stall    = (state != IDLE) & (bus.op_valid | bus.hilo_read);
    bus.hi       = hi_q;
    bus.lo       = lo_q;
  end
endmodule

// File: tb/tb_mips_hilo_sequencer.sv
// Directed self-checking bench for mips_hilo_sequencer.
module tb_mips_hilo_sequencer;
  logic clk;
  logic reset;
  logic clock_enable;
  int   checks;
  int   errors;

  mips_hilo_sequencer_if #(.WIDTH(32)) bus ();

  mips_hilo_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .clock_enable (clock_enable),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_a     = a;
    bus.op_b     = b;
    tick();
    bus.op_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until busy falls (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.busy && n < 60);
  endtask

  initial begin
    int n;
    int sc;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    clock_enable = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code = 3'b000;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.hilo_read = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_hi", 64'(bus.hi), 64'h0);
    chk("rst_lo", 64'(bus.lo), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_ready", 64'(bus.op_ready), 64'h1);
    chk("rst_stall", 64'(bus.stall), 64'h0);

    // MTLO in IDLE
    issue(3'b101, 32'hCAFEF00D, 32'h0);
    chk("mtlo_lo", 64'(bus.lo), 64'hCAFEF00D);
    chk("mtlo_hi", 64'(bus.hi), 64'h0);
    chk("mtlo_busy", 64'(bus.busy), 64'h0);

    // Reserved op code: no state change, no stall
    bus.op_valid = 1'b1;
    bus.op_code = 3'b110;
    bus.op_a = 32'h55AA55AA;
    #1;
    chk("rsv_stall", 64'(bus.stall), 64'h0);
    tick();
    bus.op_valid = 1'b0;
    chk("rsv_busy", 64'(bus.busy), 64'h0);
    chk("rsv_hilo", {bus.hi, bus.lo}, 64'h00000000_CAFEF00D);

    // MULT -3 * 7 with MFHI/MFLO read arriving mid-operation
    issue(3'b000, 32'hFFFFFFFD, 32'd7);
    repeat (4) tick();
    bus.hilo_read = 1'b1;
    #1;
    n = 4;
    sc = 0;
    while (bus.busy && n < 60) begin
      if (bus.stall) sc++;
      tick();
      n++;
    end
    chk("mult_latency", 64'(n), 64'd33);
    chk("mult_stall_cycles", 64'(sc), 64'd29);
    chk("mult_idle_read_stall", 64'(bus.stall), 64'h0);
    bus.hilo_read = 1'b0;
    chk("mult_result", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);

    // MULTU full-scale
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    chk("multu_latency", 64'(n), 64'd33);
    chk("multu_result", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);

    // DIV most-negative by -1
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("div_ovf_latency", 64'(n), 64'd33);
    chk("div_ovf_result", {bus.hi, bus.lo}, 64'h00000000_80000000);

    // DIV -7 / 2
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_neg_result", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);

    // DIVU 100 / 7
    issue(3'b011, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_result", {bus.hi, bus.lo}, 64'h00000002_0000000E);

    // DIVU 5 / 0
    issue(3'b011, 32'd5, 32'd0);
    chk("div0_busy_fix", 64'(bus.busy), 64'h1);
    tick();
    chk("div0_result", {bus.hi, bus.lo}, 64'h00000005_FFFFFFFF);
    chk("div0_busy_done", 64'(bus.busy), 64'h0);

    // MTHI held by stall during DIVU 100/7, incl. the FIX cycle
    issue(3'b011, 32'd100, 32'd7);
    repeat (9) tick();
    bus.op_valid = 1'b1;
    bus.op_code = 3'b100;
    bus.op_a = 32'h1234;
    #1;
    chk("mthi_stall", 64'(bus.stall), 64'h1);
    chk("mthi_ready", 64'(bus.op_ready), 64'h0);
    n = 9;
    sc = 0;
    while (!bus.op_ready && n < 60) begin
      if (bus.stall) sc++;
      tick();
      n++;
    end
    chk("mthi_wait_edges", 64'(n), 64'd33);
    chk("mthi_stall_cycles", 64'(sc), 64'd24);
    chk("mthi_pre_accept", {bus.hi, bus.lo}, 64'h00000002_0000000E);
    chk("mthi_idle_stall", 64'(bus.stall), 64'h0);
    tick();
    bus.op_valid = 1'b0;
    chk("mthi_post_accept", {bus.hi, bus.lo}, 64'h00001234_0000000E);
    chk("mthi_busy", 64'(bus.busy), 64'h0);

    // clock_enable low for 5 edges mid-operation
    issue(3'b001, 32'd3, 32'd5);
    n = 0;
    do begin
      n++;
      clock_enable = !(n >= 10 && n <= 14);
      if (n == 12) begin
        bus.hilo_read = 1'b1;
        #1;
        chk("ce_stall", 64'(bus.stall), 64'h1);
        bus.hilo_read = 1'b0;
      end
      tick();
    end while (bus.busy && n < 60);
    clock_enable = 1'b1;
    chk("ce_latency", 64'(n), 64'd38);
    chk("ce_result", {bus.hi, bus.lo}, 64'h00000000_0000000F);

    // Reset mid-operation, with clock_enable low to show reset wins
    issue(3'b000, 32'hFFFFFFFD, 32'd7);
    repeat (11) tick();
    reset = 1'b1;
    clock_enable = 1'b0;
    tick();
    reset = 1'b0;
    clock_enable = 1'b1;
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("rst_mid_busy", 64'(bus.busy), 64'h0);
    chk("rst_mid_ready", 64'(bus.op_ready), 64'h1);

    // Clean operation after abort
    issue(3'b001, 32'd6, 32'd7);
    wait_idle(n);
    chk("post_rst_latency", 64'(n), 64'd33);
    chk("post_rst_result", {bus.hi, bus.lo}, 64'h00000000_0000002A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
